// File: rtl/tug_pkg.sv
// Shared types and helpers for the tug-of-war playfield.
package tug_pkg;

  typedef enum logic {PLAY, WIN} field_state_t;

  typedef enum logic [1:0] {NONE = 2'd0, LEFT = 2'd1, RIGHT = 2'd2} winner_t;

  function automatic int centre(input int n);
    return n / 2;
  endfunction

endpackage

// File: rtl/tug_field_press_edge.sv
// Rising-edge qualifier for one synchronised player button.
module press_edge (
  input  logic clk,
  input  logic reset,
  input  logic in,
  output logic pulse
);

  logic in_q;
  logic armed;

  // armed masks the first edge after reset release, so a button held through
  // reset cannot fire until it is released and pressed again.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      in_q  <= 1'b0;
      armed <= 1'b0;
    end else begin
      in_q  <= in;
      armed <= 1'b1;
    end
  end

  assign pulse = in & ~in_q & armed;

endmodule

// File: rtl/tug_field.sv
// Tug-of-war playfield: single position register driving a one-hot light bar.
module tug_field
  import tug_pkg::*;
#(
  parameter int NUM_LIGHTS  = 9,
  parameter int SCORE_W     = 3,
  parameter int EDGE_DETECT = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  L,
  input  logic                  R,
  input  logic                  new_round,
  output logic [NUM_LIGHTS-1:0] lights,
  output logic [1:0]            winner,
  output logic                  round_over,
  output logic [SCORE_W-1:0]    score_l,
  output logic [SCORE_W-1:0]    score_r
);

  localparam int PW = $clog2(NUM_LIGHTS);
  localparam logic [PW-1:0] CENTRE = PW'(centre(NUM_LIGHTS));
  localparam logic [PW-1:0] LAST   = PW'(NUM_LIGHTS - 1);
  localparam logic [NUM_LIGHTS-1:0] LIGHT_ONE = NUM_LIGHTS'(1);

  if ((NUM_LIGHTS % 2 == 0) || (NUM_LIGHTS < 3)) begin : g_bad_lights
    $error("tug_field: NUM_LIGHTS must be odd and >= 3");
  end

  logic pl;
  logic pr;

  if (EDGE_DETECT != 0) begin : g_edge
    press_edge u_left (
      .clk   (clk),
      .reset (reset),
      .in    (L),
      .pulse (pl)
    );
    press_edge u_right (
      .clk   (clk),
      .reset (reset),
      .in    (R),
      .pulse (pr)
    );
  end else begin : g_raw
    assign pl = L;
    assign pr = R;
  end

  field_state_t           state, state_n;
  logic [PW-1:0]          pos, pos_n;
  winner_t                win_q, win_n;
  logic [SCORE_W-1:0]     sl_q, sl_n;
  logic [SCORE_W-1:0]     sr_q, sr_n;
  logic [NUM_LIGHTS-1:0]  lights_q, lights_n;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= PLAY;
      pos      <= CENTRE;
      win_q    <= NONE;
      sl_q     <= '0;
      sr_q     <= '0;
      lights_q <= LIGHT_ONE << CENTRE;
    end else begin
      state    <= state_n;
      pos      <= pos_n;
      win_q    <= win_n;
      sl_q     <= sl_n;
      sr_q     <= sr_n;
      lights_q <= lights_n;
    end
  end

  always_comb begin
    state_n = state;
    pos_n   = pos;
    win_n   = win_q;
    sl_n    = sl_q;
    sr_n    = sr_q;
    unique case (state)
      PLAY: begin
        if (new_round) begin
          pos_n = CENTRE;
        end else if (pl && !pr) begin
          if (pos == LAST) begin
            state_n = WIN;
            win_n   = LEFT;
            if (sl_q != '1) sl_n = sl_q + 1'b1;
          end else begin
            pos_n = pos + 1'b1;
          end
        end else if (pr && !pl) begin
          if (pos == '0) begin
            state_n = WIN;
            win_n   = RIGHT;
            if (sr_q != '1) sr_n = sr_q + 1'b1;
          end else begin
            pos_n = pos - 1'b1;
          end
        end
      end
      WIN: begin
        if (new_round) begin
          state_n = PLAY;
          pos_n   = CENTRE;
          win_n   = NONE;
        end
      end
    endcase
  end

  // Decode from next-state so the light bar lands in the same cycle as pos.
  always_comb begin
    lights_n = '0;
    if (state_n == PLAY) lights_n = LIGHT_ONE << pos_n;
  end

  assign lights     = lights_q;
  assign winner     = win_q;
  assign round_over = (state == WIN);
  assign score_l    = sl_q;
  assign score_r    = sr_q;

endmodule
